// File: rtl/zz_pkg.sv
// Shared definitions for the zig-zag walker/accumulator pair: default
// precision width, k-width helper, FSM encodings and the term-sign rule.
package zz_pkg;

    localparam int BPREC = 4;

    typedef enum logic [0:0] {
        ACC_IDLE = 1'b0,
        ACC_RUN  = 1'b1
    } acc_state_e;

    typedef enum logic [0:0] {
        OUT_EMPTY = 1'b0,
        OUT_HOLD  = 1'b1
    } out_state_e;

    // k = offw + offd needs one bit more than either offset.
    function automatic int zz_kw(input int bprec);
        return bprec + 1;
    endfunction

    // A term is negative when exactly one operand sits on its signed MSB plane.
    function automatic logic zz_term_neg(
        input logic [BPREC-1:0] offw,
        input logic [BPREC-1:0] offd,
        input logic [BPREC-1:0] pw,
        input logic [BPREC-1:0] pd,
        input logic             sw,
        input logic             sd
    );
        logic w_msb;
        logic d_msb;
        w_msb = sw & (offw == (pw - BPREC'(1'b1)));
        d_msb = sd & (offd == (pd - BPREC'(1'b1)));
        return w_msb ^ d_msb;
    endfunction

endpackage

// File: rtl/zigzag_acc_if.sv
// Term-input and result-output streams of the zig-zag accumulator.
interface zigzag_acc_if
    import zz_pkg::*;
#(
    parameter int BPREC = zz_pkg::BPREC,
    parameter int BWIN  = 8,
    parameter int BWOUT = 32
) ();

    logic             in_valid;
    logic             in_ready;
    logic [BWIN-1:0]  in_pp;
    logic [BPREC-1:0] in_offw;
    logic [BPREC-1:0] in_offd;
    logic             in_eod;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    logic [BWOUT-1:0] out_result;

    modport master (
        output in_valid, in_pp, in_offw, in_offd, in_eod, in_last, out_ready,
        input  in_ready, out_valid, out_result
    );

    modport slave (
        input  in_valid, in_pp, in_offw, in_offd, in_eod, in_last, out_ready,
        output in_ready, out_valid, out_result
    );

endinterface

// File: rtl/zigzag_acc_diag.sv
// Per-diagonal accumulator: signs the incoming term, sums it into the running
// diagonal, captures the diagonal's shift k and flags malformed terms.
module zigzag_acc_diag
    import zz_pkg::*;
#(
    parameter  int BPREC = zz_pkg::BPREC,
    parameter  int BWIN  = 8,
    localparam int DW    = BWIN + BPREC + 1,
    localparam int KW    = zz_kw(BPREC)
) (
    input  logic                 clk,
    input  logic                 clr,
    input  logic                 take,
    input  logic [BWIN-1:0]      pp,
    input  logic [BPREC-1:0]     offw,
    input  logic [BPREC-1:0]     offd,
    input  logic                 eod,
    input  logic                 last,
    input  logic [BPREC-1:0]     pw,
    input  logic [BPREC-1:0]     pd,
    input  logic                 sw,
    input  logic                 sd,
    output logic signed [DW-1:0] sum,
    output logic [KW-1:0]        shift,
    output logic                 bad
);

    logic signed [DW-1:0] diag_q;
    logic signed [DW-1:0] diag_d;
    logic [KW-1:0]        k_q;
    logic [KW-1:0]        k_d;
    logic                 first_q;
    logic                 first_d;

    logic [KW-1:0]        k_term;
    logic signed [DW-1:0] term_mag;
    logic signed [DW-1:0] term;

    // Signed term, running diagonal sum and term legality.
    always_comb begin
        k_term   = {1'b0, offw} + {1'b0, offd};
        term_mag = {{(DW-BWIN){1'b0}}, pp};
        if (zz_term_neg(offw, offd, pw, pd, sw, sd)) begin
            term = -term_mag;
        end else begin
            term = term_mag;
        end
        sum = diag_q + term;
        if (first_q) begin
            shift = k_term;
        end else begin
            shift = k_q;
        end
        // All terms of one diagonal must share the same significance.
        bad = (offw >= pw) | (offd >= pd) | (~first_q & (k_term != k_q)) | (last & ~eod);
    end

    // Next diagonal state; rejected terms leave everything untouched.
    always_comb begin
        diag_d  = diag_q;
        k_d     = k_q;
        first_d = first_q;
        if (take & ~bad) begin
            if (eod) begin
                diag_d  = {DW{1'b0}};
                k_d     = {KW{1'b0}};
                first_d = 1'b1;
            end else begin
                diag_d  = sum;
                first_d = 1'b0;
                if (first_q) begin
                    k_d = k_term;
                end else begin
                    k_d = k_q;
                end
            end
        end else begin
            diag_d = diag_q;
        end
    end

    // Diagonal registers.
    always_ff @(posedge clk) begin
        if (clr) begin
            diag_q  <= {DW{1'b0}};
            k_q     <= {KW{1'b0}};
            first_q <= 1'b1;
        end else begin
            diag_q  <= diag_d;
            k_q     <= k_d;
            first_q <= first_d;
        end
    end

endmodule

// File: rtl/zigzag_acc.sv
// Zig-zag product accumulator top: shifts each finished diagonal into the
// running total and presents the completed product through a valid/ready register.
module zigzag_acc
    import zz_pkg::*;
#(
    parameter int BPREC = zz_pkg::BPREC,
    parameter int BWIN  = 8,
    parameter int BWOUT = 32
) (
    input  logic             clk,
    input  logic             clr,
    input  logic [BPREC-1:0] pw,
    input  logic [BPREC-1:0] pd,
    input  logic             sw,
    input  logic             sd,
    zigzag_acc_if.slave      bus,
    output logic             err
);

    localparam int DW = BWIN + BPREC + 1;
    localparam int KW = zz_kw(BPREC);

    acc_state_e       acc_state_q;
    acc_state_e       acc_state_d;
    out_state_e       out_state_q;
    out_state_e       out_state_d;
    logic [BWOUT-1:0] total_q;
    logic [BWOUT-1:0] total_d;
    logic [BWOUT-1:0] result_q;
    logic [BWOUT-1:0] result_d;
    logic             err_q;
    logic             err_d;

    logic                 in_ready_s;
    logic                 take_s;
    logic                 good_s;
    logic                 done_s;
    logic signed [DW-1:0] diag_sum_s;
    logic [KW-1:0]        shift_s;
    logic                 bad_s;
    logic [BWOUT-1:0]     contrib_s;
    logic [BWOUT-1:0]     base_s;
    logic [BWOUT-1:0]     total_sum_s;

    zigzag_acc_diag #(
        .BPREC (BPREC),
        .BWIN  (BWIN)
    ) u_diag (
        .clk   (clk),
        .clr   (clr),
        .take  (take_s),
        .pp    (bus.in_pp),
        .offw  (bus.in_offw),
        .offd  (bus.in_offd),
        .eod   (bus.in_eod),
        .last  (bus.in_last),
        .pw    (pw),
        .pd    (pd),
        .sw    (sw),
        .sd    (sd),
        .sum   (diag_sum_s),
        .shift (shift_s),
        .bad   (bad_s)
    );

    // Input handshake: accept whenever the output slot is free or being freed.
    always_comb begin
        if (out_state_q == OUT_EMPTY) begin
            in_ready_s = 1'b1;
        end else begin
            in_ready_s = bus.out_ready;
        end
        take_s = bus.in_valid & in_ready_s;
        good_s = take_s & ~bad_s;
        done_s = good_s & bus.in_last;
    end

    // Weighted diagonal contribution and the updated total.
    always_comb begin
        contrib_s = {{(BWOUT-DW){diag_sum_s[DW-1]}}, diag_sum_s} << shift_s;
        if (acc_state_q == ACC_IDLE) begin
            base_s = {BWOUT{1'b0}};
        end else begin
            base_s = total_q;
        end
        total_sum_s = base_s + contrib_s;
    end

    // Accumulation FSM and total register next state.
    always_comb begin
        acc_state_d = acc_state_q;
        total_d     = total_q;
        case (acc_state_q)
            ACC_IDLE: begin
                if (good_s & ~bus.in_last) begin
                    acc_state_d = ACC_RUN;
                end else begin
                    acc_state_d = ACC_IDLE;
                end
            end
            ACC_RUN: begin
                if (done_s) begin
                    acc_state_d = ACC_IDLE;
                end else begin
                    acc_state_d = ACC_RUN;
                end
            end
            default: acc_state_d = ACC_IDLE;
        endcase
        if (done_s) begin
            total_d = {BWOUT{1'b0}};
        end else if (good_s & bus.in_eod) begin
            total_d = total_sum_s;
        end else begin
            total_d = total_q;
        end
    end

    // Output-slot FSM; a new result may replace one consumed in the same cycle.
    always_comb begin
        out_state_d = out_state_q;
        result_d    = result_q;
        case (out_state_q)
            OUT_EMPTY: begin
                if (done_s) begin
                    out_state_d = OUT_HOLD;
                end else begin
                    out_state_d = OUT_EMPTY;
                end
            end
            OUT_HOLD: begin
                if (done_s) begin
                    out_state_d = OUT_HOLD;
                end else if (bus.out_ready) begin
                    out_state_d = OUT_EMPTY;
                end else begin
                    out_state_d = OUT_HOLD;
                end
            end
            default: out_state_d = OUT_EMPTY;
        endcase
        if (done_s) begin
            result_d = total_sum_s;
        end else begin
            result_d = result_q;
        end
        err_d = err_q | (take_s & bad_s);
    end

    // State registers; clr wins over any simultaneous transfer.
    always_ff @(posedge clk) begin
        if (clr) begin
            acc_state_q <= ACC_IDLE;
            out_state_q <= OUT_EMPTY;
            total_q     <= {BWOUT{1'b0}};
            result_q    <= {BWOUT{1'b0}};
            err_q       <= 1'b0;
        end else begin
            acc_state_q <= acc_state_d;
            out_state_q <= out_state_d;
            total_q     <= total_d;
            result_q    <= result_d;
            err_q       <= err_d;
        end
    end

    assign bus.in_ready   = in_ready_s;
    assign bus.out_valid  = (out_state_q == OUT_HOLD);
    assign bus.out_result = result_q;
    assign err            = err_q;

endmodule

// File: tb/tb_zigzag_acc.sv
// Directed and randomized bench for zigzag_acc; expected products come from
// operand-level multiplication and are scored through a result queue.
module tb_zigzag_acc;

    logic       clk = 1'b0;
    logic       clr;
    logic [3:0] pw;
    logic [3:0] pd;
    logic       sw;
    logic       sd;
    logic       err;

    int          n_total = 0;
    int          n_bad   = 0;
    logic [31:0] exp_q[$];

    zigzag_acc_if tif ();

    zigzag_acc dut (
        .clk (clk),
        .clr (clr),
        .pw  (pw),
        .pd  (pd),
        .sw  (sw),
        .sd  (sd),
        .bus (tif.slave),
        .err (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, $signed(obs), $signed(exp));
        end
    endtask

    // Scoreboard consumer: every handshaken result must match the queue head.
    always @(negedge clk) begin
        if (clr === 1'b0 && tif.out_valid === 1'b1 && tif.out_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("spurious_result", 32'(exp_q.size()), 32'd1);
            end else begin
                check("result", tif.out_result, exp_q.pop_front());
            end
        end
    end

    function automatic longint sval(input logic [3:0] v, input int p, input bit s);
        if (s && v[p-1]) return longint'(v) - (longint'(1) << p);
        else return longint'(v);
    endfunction

    task automatic send(input logic [7:0] pp, input logic [3:0] ow, input logic [3:0] od,
                        input logic eod, input logic last);
        int waited = 0;
        tif.in_pp    = pp;
        tif.in_offw  = ow;
        tif.in_offd  = od;
        tif.in_eod   = eod;
        tif.in_last  = last;
        tif.in_valid = 1'b1;
        forever begin
            @(negedge clk);
            if (tif.in_ready === 1'b1) break;
            waited++;
            if (waited > 100) begin
                check("in_ready_timeout", {31'd0, tif.in_ready}, 32'd1);
                break;
            end
        end
        @(posedge clk);
        #1;
        tif.in_valid = 1'b0;
        tif.in_eod   = 1'b0;
        tif.in_last  = 1'b0;
    endtask

    task automatic pulse_clr();
        repeat (2) @(posedge clk);
        #1;
        clr = 1'b1;
        @(posedge clk);
        #1;
        clr = 1'b0;
    endtask

    task automatic run_product(input int p_w, input int p_d, input bit s_w, input bit s_d, input int nel);
        logic [3:0] w[4];
        logic [3:0] d[4];
        longint     acc = 0;
        pw = 4'(p_w);
        pd = 4'(p_d);
        sw = s_w;
        sd = s_d;
        for (int e = 0; e < nel; e++) begin
            w[e] = 4'($urandom_range(0, (1 << p_w) - 1));
            d[e] = 4'($urandom_range(0, (1 << p_d) - 1));
            acc += sval(w[e], p_w, s_w) * sval(d[e], p_d, s_d);
        end
        for (int s = 0; s <= p_w + p_d - 2; s++) begin
            int lo = (s - p_d + 1 > 0) ? s - p_d + 1 : 0;
            int hi = (s < p_w - 1) ? s : p_w - 1;
            for (int ow = lo; ow <= hi; ow++) begin
                int od = s - ow;
                int pp = 0;
                logic eod;
                logic last;
                for (int e = 0; e < nel; e++) pp += int'(w[e][ow] & d[e][od]);
                eod  = (ow == hi);
                last = eod && (s == p_w + p_d - 2);
                if (last) exp_q.push_back(acc[31:0]);
                send(8'(pp), 4'(ow), 4'(od), eod, last);
            end
        end
    endtask

    task automatic plan_stream(input bit signed_ops, input logic [31:0] expect_val);
        pw = 4'd2;
        pd = 4'd2;
        sw = signed_ops;
        sd = signed_ops;
        send(8'd3, 4'd0, 4'd0, 1'b1, 1'b0);
        send(8'd1, 4'd1, 4'd0, 1'b0, 1'b0);
        send(8'd2, 4'd0, 4'd1, 1'b1, 1'b0);
        exp_q.push_back(expect_val);
        send(8'd1, 4'd1, 4'd1, 1'b1, 1'b1);
    endtask

    initial begin
        clr           = 1'b1;
        pw            = 4'd2;
        pd            = 4'd2;
        sw            = 1'b0;
        sd            = 1'b0;
        tif.in_valid  = 1'b0;
        tif.in_pp     = 8'd0;
        tif.in_offw   = 4'd0;
        tif.in_offd   = 4'd0;
        tif.in_eod    = 1'b0;
        tif.in_last   = 1'b0;
        tif.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", {31'd0, tif.in_ready}, 32'd1);
        check("rst_out_valid", {31'd0, tif.out_valid}, 32'd0);
        check("rst_out_result", tif.out_result, 32'd0);
        check("rst_err", {31'd0, err}, 32'd0);
        @(posedge clk);
        #1;
        clr = 1'b0;

        // Unsigned then signed 2x2 stream, back to back.
        plan_stream(1'b0, 32'd13);
        @(negedge clk);
        check("latency_valid", {31'd0, tif.out_valid}, 32'd1);
        @(posedge clk);
        #1;
        plan_stream(1'b1, 32'd1);
        pw = 4'd1;
        pd = 4'd1;
        sw = 1'b0;
        sd = 1'b0;
        exp_q.push_back(32'd200);
        send(8'd200, 4'd0, 4'd0, 1'b1, 1'b1);
        repeat (2) @(posedge clk);
        #1;

        // Backpressure: result held, then released together with a new in_last.
        tif.out_ready = 1'b0;
        plan_stream(1'b0, 32'd13);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("hold_valid", {31'd0, tif.out_valid}, 32'd1);
            check("hold_in_ready", {31'd0, tif.in_ready}, 32'd0);
            check("hold_result", tif.out_result, 32'd13);
        end
        @(posedge clk);
        #1;
        pw = 4'd1;
        pd = 4'd1;
        tif.in_pp     = 8'd200;
        tif.in_offw   = 4'd0;
        tif.in_offd   = 4'd0;
        tif.in_eod    = 1'b1;
        tif.in_last   = 1'b1;
        tif.in_valid  = 1'b1;
        tif.out_ready = 1'b1;
        exp_q.push_back(32'd200);
        @(negedge clk);
        check("release_in_ready", {31'd0, tif.in_ready}, 32'd1);
        @(posedge clk);
        #1;
        tif.in_valid = 1'b0;
        @(negedge clk);
        check("release_valid", {31'd0, tif.out_valid}, 32'd1);

        // clr discards a held result.
        @(posedge clk);
        #1;
        tif.out_ready = 1'b0;
        send(8'd77, 4'd0, 4'd0, 1'b1, 1'b1);
        @(negedge clk);
        check("held_before_clr", {31'd0, tif.out_valid}, 32'd1);
        pulse_clr();
        void'(exp_q.pop_back());
        @(negedge clk);
        check("clr_out_valid", {31'd0, tif.out_valid}, 32'd0);
        check("clr_out_result", tif.out_result, 32'd0);
        check("clr_in_ready", {31'd0, tif.in_ready}, 32'd1);
        @(posedge clk);
        #1;
        tif.out_ready = 1'b1;

        // clr mid-product, then a full 3x3 product from scratch.
        pw = 4'd3;
        pd = 4'd3;
        sw = 1'b1;
        sd = 1'b0;
        send(8'd5, 4'd0, 4'd0, 1'b1, 1'b0);
        send(8'd4, 4'd1, 4'd0, 1'b0, 1'b0);
        pulse_clr();
        @(negedge clk);
        check("midclr_out_valid", {31'd0, tif.out_valid}, 32'd0);
        @(posedge clk);
        #1;
        run_product(3, 3, 1'b1, 1'b0, 4);

        // Randomized products over mixed precisions and signedness.
        run_product(2, 3, 1'b0, 1'b1, 4);
        run_product(4, 4, 1'b1, 1'b1, 4);
        run_product(3, 2, 1'b1, 1'b1, 3);
        run_product(4, 1, 1'b0, 1'b0, 4);
        run_product(1, 4, 1'b1, 1'b1, 4);
        run_product(4, 4, 1'b0, 1'b0, 4);

        // Out-of-range offset: flagged, dropped, later product unaffected.
        pulse_clr();
        @(negedge clk);
        check("err_clear", {31'd0, err}, 32'd0);
        @(posedge clk);
        #1;
        pw = 4'd2;
        pd = 4'd2;
        sw = 1'b0;
        sd = 1'b0;
        send(8'd5, 4'd2, 4'd0, 1'b1, 1'b0);
        @(negedge clk);
        check("err_offw", {31'd0, err}, 32'd1);
        @(posedge clk);
        #1;
        plan_stream(1'b0, 32'd13);
        repeat (3) @(negedge clk);
        check("err_sticky", {31'd0, err}, 32'd1);

        // in_last without in_eod is dropped.
        pulse_clr();
        @(negedge clk);
        check("err_clear2", {31'd0, err}, 32'd0);
        @(posedge clk);
        #1;
        send(8'd9, 4'd0, 4'd0, 1'b0, 1'b1);
        @(negedge clk);
        check("err_last_no_eod", {31'd0, err}, 32'd1);
        check("dropped_last_no_valid", {31'd0, tif.out_valid}, 32'd0);

        // Inconsistent k inside a diagonal is dropped; the rest still sums.
        pulse_clr();
        send(8'd2, 4'd0, 4'd1, 1'b0, 1'b0);
        send(8'd3, 4'd0, 4'd0, 1'b1, 1'b0);
        @(negedge clk);
        check("err_k_mismatch", {31'd0, err}, 32'd1);
        @(posedge clk);
        #1;
        send(8'd4, 4'd1, 4'd0, 1'b1, 1'b0);
        exp_q.push_back(32'd16);
        send(8'd1, 4'd1, 4'd1, 1'b1, 1'b1);

        repeat (5) @(negedge clk);
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/zigzag_acc.md
# zigzag_acc

Zig-zag product accumulator: the consuming end of the zig-zag address sequence. The upstream zig-zag walker emits bit-plane offsets (offw, offd) one diagonal at a time. The dot-product array then produces an unsigned partial product for each (weight bit-plane, data bit-plane) pair. This block accepts those terms in walk order, applies two's-complement sign and significance 2^(offw+offd), and emits one signed multi-bit result per completed multiplication through a valid/ready output register.

## Interface
- BPREC, 4, bitwidth of precision specifiers and offsets
- BWIN, 8, width of the unsigned partial-product input
- BWOUT, 32, width of the signed result

- clk  input  1  clock; all state updates on the rising edge
- clr  input  1  synchronous, active-high reset/clear
- pw  input  BPREC  weight precision, 1..2^BPREC-1; sampled on every accepted term
- pd  input  BPREC  data precision, 1..2^BPREC-1
- sw  input  1  weights are signed (MSB plane offw=pw-1 has negative weight)
- sd  input  1  data are signed (MSB plane offd=pd-1 has negative weight)
- in_valid  input  1  term present
- in_ready  output  1  term accepted when in_valid & in_ready
- in_pp  input  BWIN  unsigned partial product
- in_offw  input  BPREC  weight bit-plane of term
- in_offd  input  BPREC  data bit-plane of term
- in_eod  input  1  last term of the current diagonal
- in_last  input  1  last term of the multiplication; must coincide with in_eod
- out_valid  output  1  result held
- out_ready  input  1  result consumed when out_valid & out_ready
- out_result  output  BWOUT  signed product sum
- err  output  1  sticky protocol error

## Operation
- Term sign: negative iff exactly one of (sw & offw==pw-1) and (sd & offd==pd-1) holds. Term value = ±zext(in_pp).
- Diagonal accumulator diag (signed, BWIN+BPREC+1 bits) sums the terms of the current diagonal. It also captures k = offw+offd (BPREC+1 bits) on the diagonal's first term.
- On an accepted term with in_eod: total += (diag + term) << k, computed modulo 2^BWOUT. Then diag is set to 0.
- On an accepted term with in_last: out_result <= final total (including this term), out_valid <= 1, total <= 0, diag <= 0. Back-to-back multiplications need no idle cycle.
- in_ready = !out_valid | out_ready (combinational). Terms are accepted only when out_valid is clear or is being cleared in the same cycle.
- The out_valid/out_ready handshake completes in the same cycle that a new in_last is accepted. out_valid then stays 1 with the new result.
- err is set by an accepted term with offw>=pw, offd>=pd, or offw+offd != k on a non-first diagonal term. It is also set by in_last without in_eod. The offending term is dropped (no accumulator change); all other terms proceed. err clears only on clr.
- States: IDLE (diag empty, total 0), ACC (mid-multiplication), HOLD (out_valid=1). IDLE/ACC and HOLD are orthogonal: accumulation of the next multiplication may run while HOLD persists, up to its in_last.

## Timing
- Reset values: in_ready=1, out_valid=0, out_result=0, err=0; diag, total and k are 0.
- Latency: the result appears on the cycle after the in_last term is accepted.
- clr mid-multiplication discards partial sums and any held result. clr overrides a simultaneous input transfer.
- Precision inputs must be stable for the duration of one multiplication. Changing them mid-multiplication is undefined except for the err checks.

## Structure
- Shared package zz_pkg: BPREC default, the k-width function, and the term-sign function. The zig-zag walker reuses the sign rule.
- One sub-module, zigzag_acc_diag: per-diagonal accumulator, k capture, and the consistency check feeding err. The top level holds total, the output register and the handshake.

## Test plan
- Unsigned, pw=2, pd=2: terms (0,0)=3 eod; (1,0)=1, (0,1)=2 eod; (1,1)=1 eod+last -> out_result=13 one cycle later.
- Same stream with sw=sd=1 -> terms +3, -1, -2, +1 -> out_result=1.
- pw=pd=1: single term in_pp=200 with eod+last -> 200.
- out_ready=0 while out_valid=1 -> in_ready=0, result held stable. Raising out_ready with in_valid and in_last in the same cycle -> new result next cycle, no lost term.
- clr asserted after two terms of a pw=3, pd=3 product -> out_valid=0, the next full product is computed from zero and matches the reference model.
- Term offw=2 with pw=2 -> err=1 and the term is dropped; a following valid product is still correct; err stays 1 until clr.
